pipe_reg_chain: RTL and testbench

Parametrised, elastic register pipeline. It succeeds the team's fixed 8-bit D-register with configurable data width, stage count and reset value. It adds a valid/ready handshake per end, bubble collapsing, a synchronous flush and an occupancy count. It sits on datapath boundaries where a fixed-latency retiming delay must also honour downstream back-pressure.

---
 rtl/pipe_reg_chain.sv | 81 ++++++++
 tb/tb_pipe_reg_chain.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - elastic valid/ready register pipeline with bubble collapse, flush and occupancy count
module pipe_reg_chain #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             accept;
  logic             deliver;

  // A stage advances when it is valid and the slot ahead is empty or itself advancing;
  // this ripples out_ready back through every stage, so empty slots collapse every edge.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
    end
  end

  assign in_ready = ~flush & (~v_q[0] | adv[0]);
  assign accept   = in_valid & in_ready;
  assign deliver  = v_q[DEPTH-1] & out_ready;

  always_comb begin
    load    = '0;
    v_d     = '0;
    d_d     = d_q;
    load[0] = accept;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
    end
    d_d[0] = load[0] ? in_data : d_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      d_d[i] = load[i] ? d_q[i-1] : d_q[i];
    end
    // Flush drops only the valid bits; data registers keep shifting harmlessly.
    for (int i = 0; i < DEPTH; i++) begin
      v_d[i] = ~flush & (load[i] | (v_q[i] & ~adv[i]));
    end
    count_d = flush ? '0 : count_q + CW'(accept) - CW'(deliver);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RST_VAL;
      end
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed and randomized checks of pipe_reg_chain against a slot-position queue model
module tb_pipe_reg_chain;
  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] RST_VAL = 8'hA5;
  localparam int         CW      = $clog2(DEPTH+1);

  logic          sclk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]    in_data, out_data;
  logic [CW-1:0] count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  // Model: words oldest-first, each with the slot index it occupies.
  logic [7:0] m_data[$];
  int         m_pos[$];
  bit         exp_in_ready;
  bit         exp_accept;
  logic       act_in_ready;

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .sclk(sclk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 sclk = ~sclk;

  // Each word moves one slot forward unless blocked by the word ahead of it (after that word moved).
  task automatic tick();
    int np[$];
    int limit;
    int n;
    bit leave;
    logic [7:0] din;
    limit = DEPTH-1;
    leave = 1'b0;
    din   = in_data;
    for (int k = 0; k < m_pos.size(); k++) begin
      if (k == 0 && m_pos[0] == DEPTH-1 && out_ready) begin
        leave = 1'b1;
        np.push_back(DEPTH);
      end else begin
        n = (m_pos[k] + 1 < limit) ? m_pos[k] + 1 : limit;
        np.push_back(n);
        limit = n - 1;
      end
    end
    exp_in_ready = !flush && (m_pos.size() == 0 || np[np.size()-1] >= 1);
    exp_accept   = !rst && in_valid && exp_in_ready;
    @(negedge sclk);
    act_in_ready = in_ready;
    @(posedge sclk);
    if (rst || flush) begin
      m_pos.delete();
      m_data.delete();
    end else begin
      m_pos = np;
      if (leave) begin
        void'(m_pos.pop_front());
        void'(m_data.pop_front());
      end
      if (exp_accept) begin
        m_pos.push_back(0);
        m_data.push_back(din);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = 8'($urandom);
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== RST_VAL) $display("FAIL reset_out_data got %h want %h", out_data, RST_VAL); else pass_cnt++;
    chk_cnt++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    tick();
    chk_cnt++; if (count !== '0) $display("FAIL reset_no_accept count got %0d want 0", count); else pass_cnt++;
    chk_cnt++; if (act_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", act_in_ready); else pass_cnt++;
  endtask

  task automatic test_streaming();
    int acc_cyc[$];
    int seen_cyc[$];
    logic [7:0] seen[$];
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h01 + i);
      tick();
      chk_cnt++; if (act_in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b want 1", i, act_in_ready); else pass_cnt++;
      if (act_in_ready === 1'b1) acc_cyc.push_back(cyc);
      if (out_valid === 1'b1) begin seen.push_back(out_data); seen_cyc.push_back(cyc); end
      if (i >= DEPTH-1) begin
        chk_cnt++; if (count !== CW'(DEPTH)) $display("FAIL stream_count[%0d] got %0d want %0d", i, count, DEPTH); else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 20 && seen.size() < 8; t++) begin
      tick();
      if (out_valid === 1'b1) begin seen.push_back(out_data); seen_cyc.push_back(cyc); end
    end
    chk_cnt++; if (seen.size() != 8) $display("FAIL stream_words got %0d want 8", seen.size()); else pass_cnt++;
    for (int k = 0; k < seen.size(); k++) begin
      chk_cnt++; if (seen[k] !== 8'(8'h01 + k)) $display("FAIL stream_order[%0d] got %h want %h", k, seen[k], 8'(8'h01 + k)); else pass_cnt++;
    end
    if (seen.size() == 8 && acc_cyc.size() > 0) begin
      chk_cnt++; if (seen_cyc[0] - acc_cyc[0] != DEPTH-1) $display("FAIL stream_latency got %0d want %0d", seen_cyc[0] - acc_cyc[0], DEPTH-1); else pass_cnt++;
      chk_cnt++; if (seen_cyc[7] - seen_cyc[0] != 7) $display("FAIL stream_back_to_back got %0d want 7", seen_cyc[7] - seen_cyc[0]); else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    out_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      in_valid = (idx < 6); in_data = 8'(8'h10 + idx);
      tick();
      chk_cnt++; if (act_in_ready !== (t < DEPTH)) $display("FAIL bp_in_ready[%0d] got %b want %b", t, act_in_ready, (t < DEPTH)); else pass_cnt++;
      if (act_in_ready === 1'b1 && in_valid) idx++;
    end
    in_valid = 1'b0;
    chk_cnt++; if (idx != 4) $display("FAIL bp_accepted got %0d want 4", idx); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h10) $display("FAIL bp_out_data got %h want 10", out_data); else pass_cnt++;
    chk_cnt++; if (count !== CW'(4)) $display("FAIL bp_count got %0d want 4", count); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_cnt++; if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + k)) $display("FAIL bp_drain[%0d] got %b/%h want 1/%h", k, out_valid, out_data, 8'(8'h10 + k)); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h20; tick();
    in_data = 8'h21; tick();
    in_valid = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    chk_cnt++; if (count !== CW'(2) || out_valid !== 1'b1 || out_data !== 8'h20) $display("FAIL bubble_held got %0d/%b/%h want 2/1/20", count, out_valid, out_data); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    chk_cnt++; if (count !== CW'(1) || out_valid !== 1'b1 || out_data !== 8'h21) $display("FAIL bubble_second got %0d/%b/%h want 1/1/21", count, out_valid, out_data); else pass_cnt++;
    tick();
    chk_cnt++; if (count !== '0 || out_valid !== 1'b0) $display("FAIL bubble_empty got %0d/%b want 0/0", count, out_valid); else pass_cnt++;
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_data = 8'(8'h30 + i); tick(); end
    chk_cnt++; if (count !== CW'(4)) $display("FAIL full_fill_count got %0d want 4", count); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 8'(8'h34 + k);
      tick();
      chk_cnt++; if (act_in_ready !== 1'b1) $display("FAIL full_accept[%0d] got %b want 1", k, act_in_ready); else pass_cnt++;
      chk_cnt++; if (out_data !== 8'(8'h31 + k) || count !== CW'(4)) $display("FAIL full_deliver[%0d] got %h/%0d want %h/4", k, out_data, count, 8'(8'h31 + k)); else pass_cnt++;
    end
    in_valid = 1'b0;
    for (int t = 0; t < 10 && out_valid === 1'b1; t++) tick();
    chk_cnt++; if (count !== '0) $display("FAIL full_drain_count got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_flush_restart(input bit use_rst);
    int acc;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 8'(8'h40 + i); tick(); end
    chk_cnt++; if (count !== CW'(3)) $display("FAIL restart_fill_count[%0d] got %0d want 3", use_rst, count); else pass_cnt++;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    in_data = 8'h43;
    tick();
    if (!use_rst) begin
      chk_cnt++; if (act_in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", act_in_ready); else pass_cnt++;
    end else begin
      chk_cnt++; if (out_data !== RST_VAL) $display("FAIL rst_out_data got %h want %h", out_data, RST_VAL); else pass_cnt++;
    end
    rst = 1'b0; flush = 1'b0;
    chk_cnt++; if (count !== '0 || out_valid !== 1'b0) $display("FAIL restart_cleared[%0d] got %0d/%b want 0/0", use_rst, count, out_valid); else pass_cnt++;
    in_data = 8'h44;
    tick();
    acc = cyc;
    chk_cnt++; if (act_in_ready !== 1'b1) $display("FAIL restart_accept[%0d] got %b want 1", use_rst, act_in_ready); else pass_cnt++;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 10 && out_valid !== 1'b1; t++) tick();
    chk_cnt++; if (cyc - acc != DEPTH-1 || out_data !== 8'h44) $display("FAIL restart_latency[%0d] got %0d/%h want %0d/44", use_rst, cyc - acc, out_data, DEPTH-1); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0) || (t % 100 > 80);
      if (t % 100 > 60 && t % 100 < 75) out_ready = 1'b0;
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 90) == 0);
      in_data   = 8'($urandom);
      tick();
      chk_cnt++; if (act_in_ready !== exp_in_ready) $display("FAIL rand_in_ready[%0d] got %b want %b", t, act_in_ready, exp_in_ready); else pass_cnt++;
      chk_cnt++; if (count !== CW'(m_pos.size())) $display("FAIL rand_count[%0d] got %0d want %0d", t, count, m_pos.size()); else pass_cnt++;
      chk_cnt++; if (out_valid !== (m_pos.size() > 0 && m_pos[0] == DEPTH-1)) $display("FAIL rand_out_valid[%0d] got %b", t, out_valid); else pass_cnt++;
      if (m_pos.size() > 0 && m_pos[0] == DEPTH-1) begin
        chk_cnt++; if (out_data !== m_data[0]) $display("FAIL rand_out_data[%0d] got %h want %h", t, out_data, m_data[0]); else pass_cnt++;
      end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_full_simul();
    test_flush_restart(1'b0);
    test_flush_restart(1'b1);
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
